fifo_rd_stream: RTL

- Downstream consumer of the synchronous FIFO: drives the FIFO read side (rd_en, data_out, empty) and presents the words as a valid/ready stream to the next stage.
- Absorbs the FIFO's 1-cycle registered read latency with a 2-entry skid buffer, so the stream runs at full throughput without ever reading an empty FIFO.
- Adds enable/flush control, a drained-word counter and a sticky underflow error.

---
 rtl/shared_pkg.sv | 14 +
 rtl/fifo_rd_stream_skid_buf2.sv | 66 ++++++
 rtl/fifo_rd_stream_sva.sv | 24 ++
 rtl/fifo_rd_stream.sv | 100 ++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared FIFO-side definitions: data width, drained-word counter width and
// the read-stream controller state encoding.
package shared_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    RS_IDLE  = 2'd0,
    RS_RUN   = 2'd1,
    RS_FLUSH = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry register skid buffer. Entry 0 is always the head, so pops shift
// entry 1 down and the head is a plain register with no read mux.
module skid_buf2 #(
  parameter int W = shared_pkg::FIFO_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   occ,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else if (clear) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            ent0 <= din;
            occ  <= 2'd1;
          end else if (occ == 2'd1) begin
            ent1 <= din;
            occ  <= 2'd2;
          end
        end
        2'b01: begin
          if (occ != 2'd0) begin
            ent0 <= ent1;
            occ  <= occ - 2'd1;
          end
        end
        2'b11: begin
          // A pop from an empty buffer cannot happen; treat it as a plain push.
          if (occ == 2'd2) begin
            ent0 <= ent1;
            ent1 <= din;
          end else begin
            ent0 <= din;
            occ  <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = ent0;
  assign full  = (occ == 2'd2);
  assign empty = (occ == 2'd0);

endmodule

// File: rtl/fifo_rd_stream_sva.sv
// Bound-in protocol checks: never read an empty FIFO, never overfill the buffer.
module fifo_rd_stream_sva (
  input logic       clk,
  input logic       rst_n,
  input logic       fifo_rd_en,
  input logic       fifo_empty,
  input logic [1:0] occ
);

  a_no_rd_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_rd_en && fifo_empty));

  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n)
    occ <= 2'd2);

endmodule

bind fifo_rd_stream fifo_rd_stream_sva u_sva (
  .clk        (clk),
  .rst_n      (rst_n),
  .fifo_rd_en (fifo_rd_en),
  .fifo_empty (fifo_empty),
  .occ        (occ)
);

// File: rtl/fifo_rd_stream.sv
// FIFO read-side consumer: pulls words with rd_en, absorbs the 1-cycle read
// latency in a 2-entry skid buffer and presents them as a valid/ready stream.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = shared_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  drained_cnt,
  output logic                  busy,
  output logic                  err_underflow
);

  import shared_pkg::*;

  // state    | meaning
  // RS_IDLE  | no reads issued; buffered words still drain
  // RS_RUN   | reads issued while the buffer has room
  // RS_FLUSH | no reads; buffer and landing word discarded

  localparam logic [2:0] BUF_LIM = 3'(BUF_DEPTH);

  rd_state_e state;
  rd_state_e state_nxt;
  logic      inflight;
  logic      pop;
  logic      discard;
  logic      buf_push;
  logic      buf_full;
  logic      buf_empty;
  logic [1:0] occ;
  logic [2:0] level;

  assign pop     = m_valid && m_ready;
  assign discard = flush || (state == RS_FLUSH);
  assign buf_push = inflight && !discard && (!buf_full || pop);

  // Occupancy after this cycle's pop, counting the word already in flight.
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign fifo_rd_en = (state == RS_RUN) && !flush && !fifo_empty && (level < BUF_LIM);
  assign m_valid    = !buf_empty && (state != RS_FLUSH);
  assign busy       = (state != RS_IDLE) || (occ != 2'd0) || inflight;

  skid_buf2 #(.W(FIFO_WIDTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (discard),
    .push  (buf_push),
    .pop   (pop),
    .din   (fifo_data_out),
    .head  (m_data),
    .occ   (occ),
    .full  (buf_full),
    .empty (buf_empty)
  );

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RS_FLUSH;
    end else begin
      case (state)
        RS_IDLE:  if (enable)    state_nxt = RS_RUN;
        RS_RUN:   if (!enable)   state_nxt = RS_IDLE;
        RS_FLUSH: if (!inflight) state_nxt = RS_IDLE;
        default:                 state_nxt = RS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RS_IDLE;
      inflight      <= 1'b0;
      drained_cnt   <= '0;
      err_underflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      if (pop) begin
        drained_cnt <= drained_cnt + 1'b1;
      end
      if (fifo_underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule
